gnn_node_scheduler: RTL and testbench

Frame-level controller for the four-node GNN inference datapath. It accepts one input frame through a valid/ready handshake and time-multiplexes a single shared, in-order pipelined hidden-layer+ReLU unit across nodes 0..3. It steers the returned results into the node result buffer and launches the post-ReLU aggregation/output stage. It then collects the eight output-ready flags and signals frame completion. A watchdog and a protocol checker raise a sticky error on stalls or out-of-order returns.

---
 rtl/gnn_node_scheduler_if.sv | 34 +++
 rtl/gnn_node_scheduler.sv | 151 +++++++++++++++
 tb/tb_gnn_node_scheduler.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gnn_node_scheduler_if.sv
// Control bundle between the GNN frame scheduler and its datapath: the frame
// handshake, the shared hidden-unit issue/return port, result-buffer write
// steering, output-aggregation start and the output-ready flags.
interface gnn_node_scheduler_if #(
   parameter int OUT_FLAGS = 8
);
   logic                 frame_valid;
   logic                 frame_ready;
   logic                 hid_issue;
   logic [1:0]           hid_node;
   logic                 hid_ret;
   logic [1:0]           hid_ret_node;
   logic                 buf_we;
   logic [1:0]           buf_waddr;
   logic                 oagg_start;
   logic [OUT_FLAGS-1:0] out_ready;
   logic                 frame_done;
   logic                 busy;
   logic                 err;

   // Scheduler side.
   modport master (
      input  frame_valid, hid_ret, hid_ret_node, out_ready,
      output frame_ready, hid_issue, hid_node, buf_we, buf_waddr,
             oagg_start, frame_done, busy, err
   );

   // Datapath / frame source side.
   modport slave (
      output frame_valid, hid_ret, hid_ret_node, out_ready,
      input  frame_ready, hid_issue, hid_node, buf_we, buf_waddr,
             oagg_start, frame_done, busy, err
   );
endinterface

// File: rtl/gnn_node_scheduler.sv
// Frame-level controller for the four-node GNN datapath. Accepts a frame,
// issues nodes 0..3 to the shared pipelined hidden unit, steers in-order
// returns into the result buffer, starts output aggregation, collects the
// output-ready flags and pulses frame_done. A watchdog aborts stalled frames
// and a sticky err flags timeouts and unexpected returns.
module gnn_node_scheduler #(
   parameter int TIMEOUT   = 32,
   parameter int OUT_FLAGS = 8
) (
   input  logic                 gated_clk,
   input  logic                 rst_n,
   gnn_node_scheduler_if.master bus
);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_RET,
      OAGG,
      WAIT_OUT
   } state_t;

   localparam logic [2:0] NODES     = 3'd4;
   localparam logic [2:0] LAST_NODE = 3'd3;
   localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

   state_t               state;
   state_t               state_nxt;
   logic [2:0]           iss_cnt;
   logic [2:0]           ret_cnt;
   logic [7:0]           wdog;
   logic [OUT_FLAGS-1:0] flag_coll;
   logic                 frame_done_q;
   logic                 err_q;

   logic                 accept;
   logic                 ret_ok;
   logic                 ret_bad;
   logic                 ret_all;
   logic                 flags_all;
   logic                 complete;
   logic                 abort;

   logic                 frame_ready_c;
   logic                 hid_issue_c;
   logic [1:0]           hid_node_c;
   logic                 oagg_start_c;
   logic                 busy_c;

   // Classify this cycle's return and detect frame-level events.
   always_comb begin
      accept    = (state == IDLE) && bus.frame_valid;
      ret_ok    = bus.hid_ret
                  && ((state == ISSUE) || (state == WAIT_RET))
                  && (ret_cnt < NODES)
                  && (bus.hid_ret_node == ret_cnt[1:0]);
      ret_bad   = bus.hid_ret && !ret_ok;
      // True on the edge where the fourth return lands (or has landed).
      ret_all   = (ret_cnt == NODES) || (ret_ok && (ret_cnt == LAST_NODE));
      flags_all = &(flag_coll | bus.out_ready);
      complete  = (state == WAIT_OUT) && flags_all;
      // Completion in the timeout cycle wins over the abort.
      abort     = (state != IDLE) && (wdog == WDOG_LAST) && !complete;
   end

   // Next-state logic and Moore outputs; a watchdog abort forces IDLE.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
      state_nxt     = state;
      frame_ready_c = 1'b0;
      hid_issue_c   = 1'b0;
      hid_node_c    = 2'd0;
      oagg_start_c  = 1'b0;
      busy_c        = 1'b1;
      case (state)
         IDLE: begin
            frame_ready_c = 1'b1;
            busy_c        = 1'b0;
            if (bus.frame_valid) state_nxt = ISSUE;
         end
         ISSUE: begin
            hid_issue_c = 1'b1;
            hid_node_c  = iss_cnt[1:0];
            if (iss_cnt == LAST_NODE) state_nxt = ret_all ? OAGG : WAIT_RET;
         end
         WAIT_RET: begin
            if (ret_all) state_nxt = OAGG;
         end
         OAGG: begin
            oagg_start_c = 1'b1;
            state_nxt    = WAIT_OUT;
         end
         WAIT_OUT: begin
            if (flags_all) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (abort) state_nxt = IDLE;
   end

   // State register.
   always_ff @(posedge gated_clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Issue/return counters, watchdog and output-flag collector.
   always_ff @(posedge gated_clk or negedge rst_n) begin
      if (!rst_n) begin
         iss_cnt   <= 3'd0;
         ret_cnt   <= 3'd0;
         wdog      <= 8'd0;
         flag_coll <= '0;
      end else if (accept) begin
         iss_cnt   <= 3'd0;
         ret_cnt   <= 3'd0;
         wdog      <= 8'd0;
         flag_coll <= '0;
      end else begin
         if ((state == ISSUE) && (iss_cnt < NODES)) iss_cnt <= iss_cnt + 3'd1;
         // ret_ok already implies ret_cnt < 4, so the count saturates at 4.
         if (ret_ok) ret_cnt <= ret_cnt + 3'd1;
         if (state != IDLE) wdog <= wdog + 8'd1;
         if (state == OAGG)          flag_coll <= '0;
         else if (state == WAIT_OUT) flag_coll <= flag_coll | bus.out_ready;
      end
   end

   // Registered completion pulse and sticky error.
   always_ff @(posedge gated_clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_done_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         frame_done_q <= complete;
         if (ret_bad || abort) err_q <= 1'b1;
      end
   end

   assign bus.frame_ready = frame_ready_c;
   assign bus.hid_issue   = hid_issue_c;
   assign bus.hid_node    = hid_node_c;
   assign bus.oagg_start  = oagg_start_c;
   assign bus.busy        = busy_c;
   assign bus.buf_we      = ret_ok;
   assign bus.buf_waddr   = bus.hid_ret_node;
   assign bus.frame_done  = frame_done_q;
   assign bus.err         = err_q;

endmodule

// File: tb/tb_gnn_node_scheduler.sv
// Self-checking bench for gnn_node_scheduler. A frame-progress model (age
// since accept, returns seen, cycles since the last return) predicts every
// output each cycle; directed frames add hand-computed literal expectations.
module tb_gnn_node_scheduler;

   localparam int TIMEOUT   = 32;
   localparam int OUT_FLAGS = 8;
   localparam logic [OUT_FLAGS-1:0] ALL_FLAGS = '1;

   logic gated_clk = 1'b0;
   logic rst_n     = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;
   int lit_cyc = 0;

   gnn_node_scheduler_if #(.OUT_FLAGS(OUT_FLAGS)) bus ();

   gnn_node_scheduler #(
      .TIMEOUT  (TIMEOUT),
      .OUT_FLAGS(OUT_FLAGS)
   ) dut (
      .gated_clk(gated_clk),
      .rst_n    (rst_n),
      .bus      (bus)
   );

   always #5 gated_clk = ~gated_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit                   m_active = 1'b0;
   int                   m_age    = 0;   // 1 in the first busy cycle
   int                   m_rets   = 0;   // in-order returns accepted
   int                   m_post   = 0;   // cycles since 4th return (0 = aggregation start cycle)
   logic [OUT_FLAGS-1:0] m_coll   = '0;
   bit                   m_err    = 1'b0;
   bit                   m_done   = 1'b0;
   int                   m_was_rets;
   bit                   m_good;
   bit                   m_done_now;

   // Advance the model one clock edge from the inputs applied during the cycle.
   always @(posedge gated_clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active = 1'b0; m_age = 0; m_rets = 0; m_post = 0;
         m_coll = '0; m_err = 1'b0; m_done = 1'b0;
      end else begin
         m_done_now = 1'b0;
         m_was_rets = m_rets;
         m_good = bus.hid_ret && m_active && (m_rets < 4) && (int'(bus.hid_ret_node) == m_rets);
         if (bus.hid_ret && !m_good) m_err = 1'b1;
         if (m_active) begin
            if ((m_was_rets == 4) && (m_post >= 1) && ((m_coll | bus.out_ready) == ALL_FLAGS)) begin
               m_active = 1'b0;
               m_done_now = 1'b1;
            end else if (m_age == TIMEOUT) begin
               m_active = 1'b0;
               m_err = 1'b1;
            end else begin
               m_age++;
               if (m_was_rets == 4) begin
                  if (m_post == 0) m_coll = '0;
                  else             m_coll = m_coll | bus.out_ready;
                  m_post++;
               end
               if (m_good) begin
                  m_rets++;
                  if (m_rets == 4) m_post = 0;
               end
            end
         end else if (bus.frame_valid) begin
            m_active = 1'b1; m_age = 1; m_rets = 0; m_post = 0; m_coll = '0;
         end
         m_done = m_done_now;
      end
   end

   // Compare every DUT output against the model mid-cycle.
   always @(negedge gated_clk) begin
      bit e_iss;
      e_iss = m_active && (m_age <= 4);
      check("cmp_frame_ready", 32'(bus.frame_ready), 32'(!m_active));
      check("cmp_busy",        32'(bus.busy),        32'(m_active));
      check("cmp_hid_issue",   32'(bus.hid_issue),   32'(e_iss));
      check("cmp_hid_node",    32'(bus.hid_node),    e_iss ? 32'(m_age - 1) : 32'd0);
      check("cmp_buf_we",      32'(bus.buf_we),
            32'(bus.hid_ret && m_active && (m_rets < 4) && (int'(bus.hid_ret_node) == m_rets)));
      check("cmp_buf_waddr",   32'(bus.buf_waddr),   32'(bus.hid_ret_node));
      check("cmp_oagg_start",  32'(bus.oagg_start),  32'(m_active && (m_rets == 4) && (m_post == 0)));
      check("cmp_frame_done",  32'(bus.frame_done),  32'(m_done));
      check("cmp_err",         32'(bus.err),         32'(m_err));
   end

   // ---------------- stimulus helpers ----------------
   task automatic step(input logic fv, input logic r, input logic [1:0] rn, input logic [7:0] fl);
      bus.frame_valid  = fv;
      bus.hid_ret      = r;
      bus.hid_ret_node = rn;
      bus.out_ready    = fl;
      @(posedge gated_clk);
      #1;
   endtask

   // One frame: accept in cycle 0, unit latency lat, flags fa/fb in cycles ff/ff+1.
   task automatic run_frame(input int lat, input int ff, input logic [7:0] fa,
                            input logic [7:0] fb, input logic hold);
      for (int c = 0; c <= ff + 1; c++) begin
         logic       r;
         logic [1:0] rn;
         logic [7:0] fl;
         logic       fv;
         r  = (c >= 1 + lat) && (c <= 4 + lat);
         rn = r ? 2'(c - 1 - lat) : 2'd0;
         fl = (c == ff) ? fa : ((c == ff + 1) ? fb : 8'h00);
         fv = (c == 0) || (hold && (c >= ff));
         step(fv, r, rn, fl);
      end
   endtask

   // Move a literal-check thread to the middle of relative cycle k.
   task automatic skip_to(input int k);
      repeat (k - lit_cyc) @(posedge gated_clk);
      #2;
      lit_cyc = k;
   endtask

   task automatic do_reset();
      bus.frame_valid = 1'b0; bus.hid_ret = 1'b0; bus.hid_ret_node = 2'd0; bus.out_ready = '0;
      rst_n = 1'b0;
      @(posedge gated_clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: bench exceeded its time budget");
      $fatal(1, "time budget expired");
   end

   // ---------------- directed sequence ----------------
   initial begin
      bus.frame_valid = 1'b0; bus.hid_ret = 1'b0; bus.hid_ret_node = 2'd0; bus.out_ready = '0;
      rst_n = 1'b0;
      #2;
      check("rst_frame_ready", 32'(bus.frame_ready), 32'd1);
      check("rst_busy",        32'(bus.busy),        32'd0);
      check("rst_hid_issue",   32'(bus.hid_issue),   32'd0);
      check("rst_err",         32'(bus.err),         32'd0);
      check("rst_frame_done",  32'(bus.frame_done),  32'd0);
      repeat (2) @(posedge gated_clk);
      #1;
      rst_n = 1'b1;
      step(0, 0, 2'd0, 8'h00);

      // Three back-to-back frames (L=3, L=0, L=5) with frame_valid held.
      lit_cyc = 0;
      fork
         begin
            run_frame(3, 9, 8'h0F, 8'hF0, 1'b1);
            run_frame(0, 7, 8'hAA, 8'h55, 1'b1);
            run_frame(5, 12, 8'hFF, 8'h00, 1'b0);
         end
         begin
            skip_to(0);  check("l3_c0_ready",  32'(bus.frame_ready), 32'd1);
            skip_to(1);  check("l3_c1_issue",  32'(bus.hid_issue),   32'd1);
                         check("l3_c1_node",   32'(bus.hid_node),    32'd0);
                         check("l3_c1_busy",   32'(bus.busy),        32'd1);
            skip_to(3);  check("l3_c3_node",   32'(bus.hid_node),    32'd2);
            skip_to(4);  check("l3_c4_node",   32'(bus.hid_node),    32'd3);
                         check("l3_c4_we",     32'(bus.buf_we),      32'd1);
                         check("l3_c4_waddr",  32'(bus.buf_waddr),   32'd0);
            skip_to(5);  check("l3_c5_issue",  32'(bus.hid_issue),   32'd0);
            skip_to(7);  check("l3_c7_we",     32'(bus.buf_we),      32'd1);
                         check("l3_c7_waddr",  32'(bus.buf_waddr),   32'd3);
            skip_to(8);  check("l3_c8_oagg",   32'(bus.oagg_start),  32'd1);
            skip_to(9);  check("l3_c9_oagg",   32'(bus.oagg_start),  32'd0);
            skip_to(10); check("l3_c10_done",  32'(bus.frame_done),  32'd0);
            skip_to(11); check("l3_c11_done",  32'(bus.frame_done),  32'd1);
                         check("l3_c11_ready", 32'(bus.frame_ready), 32'd1);
                         check("l3_c11_err",   32'(bus.err),         32'd0);
            skip_to(12); check("b2b_c12_done", 32'(bus.frame_done),  32'd0);
                         check("b2b_c12_busy", 32'(bus.busy),        32'd1);
                         check("b2b_c12_node", 32'(bus.hid_node),    32'd0);
                         check("b2b_c12_we",   32'(bus.buf_we),      32'd1);
         end
      join

      // Reset pulsed while node 2 is being issued, then a fresh frame.
      step(1, 0, 2'd0, 8'h00);
      step(0, 0, 2'd0, 8'h00);
      step(0, 0, 2'd0, 8'h00);
      #1;
      check("pre_rst_node", 32'(bus.hid_node), 32'd2);
      rst_n = 1'b0;
      #1;
      check("mid_rst_ready", 32'(bus.frame_ready), 32'd1);
      check("mid_rst_issue", 32'(bus.hid_issue),   32'd0);
      check("mid_rst_node",  32'(bus.hid_node),    32'd0);
      check("mid_rst_busy",  32'(bus.busy),        32'd0);
      @(posedge gated_clk);
      #1;
      rst_n = 1'b1;
      lit_cyc = 0;
      fork
         run_frame(1, 8, 8'hFF, 8'h00, 1'b0);
         begin
            skip_to(1); check("reissue_c1_issue", 32'(bus.hid_issue),  32'd1);
                        check("reissue_c1_node",  32'(bus.hid_node),   32'd0);
            skip_to(2); check("reissue_c2_waddr", 32'(bus.buf_waddr),  32'd0);
                        check("reissue_c2_we",    32'(bus.buf_we),     32'd1);
            skip_to(9); check("reissue_c9_done",  32'(bus.frame_done), 32'd1);
         end
      join

      // Completion in the very cycle the watchdog expires: completion wins.
      lit_cyc = 0;
      fork
         run_frame(3, 31, 8'h00, 8'hFF, 1'b0);
         begin
            skip_to(32); check("edge_c32_busy",  32'(bus.busy),        32'd1);
            skip_to(33); check("edge_c33_done",  32'(bus.frame_done),  32'd1);
                         check("edge_c33_err",   32'(bus.err),         32'd0);
                         check("edge_c33_ready", 32'(bus.frame_ready), 32'd1);
         end
      join

      // Return while IDLE.
      bus.hid_ret = 1'b1; bus.hid_ret_node = 2'd1;
      #2;
      check("idle_ret_we",    32'(bus.buf_we),    32'd0);
      check("idle_ret_waddr", 32'(bus.buf_waddr), 32'd1);
      check("idle_ret_err0",  32'(bus.err),       32'd0);
      @(posedge gated_clk);
      #1;
      bus.hid_ret = 1'b0; bus.hid_ret_node = 2'd0;
      #1;
      check("idle_ret_err1",  32'(bus.err),         32'd1);
      check("idle_ret_ready", 32'(bus.frame_ready), 32'd1);
      check("idle_ret_busy",  32'(bus.busy),        32'd0);
      do_reset();
      #1;
      check("post_rst_err", 32'(bus.err), 32'd0);

      // Out-of-order return 0 then 2, followed by a watchdog abort.
      lit_cyc = 0;
      fork
         for (int c = 0; c <= 32; c++)
            step(c == 0, (c == 4) || (c == 5), (c == 5) ? 2'd2 : 2'd0, 8'h00);
         begin
            skip_to(4);  check("ooo_c4_we",     32'(bus.buf_we),      32'd1);
            skip_to(5);  check("ooo_c5_we",     32'(bus.buf_we),      32'd0);
                         check("ooo_c5_err",    32'(bus.err),         32'd0);
            skip_to(6);  check("ooo_c6_err",    32'(bus.err),         32'd1);
            skip_to(32); check("ooo_c32_busy",  32'(bus.busy),        32'd1);
            skip_to(33); check("ooo_c33_busy",  32'(bus.busy),        32'd0);
                         check("ooo_c33_ready", 32'(bus.frame_ready), 32'd1);
                         check("ooo_c33_done",  32'(bus.frame_done),  32'd0);
         end
      join
      do_reset();

      // Output flags stuck at 0x7F: watchdog abort in non-IDLE cycle 32.
      lit_cyc = 0;
      fork
         for (int c = 0; c <= 32; c++)
            step(c == 0, (c >= 3) && (c <= 6), ((c >= 3) && (c <= 6)) ? 2'(c - 3) : 2'd0, 8'h7F);
         begin
            skip_to(7);  check("stuck_c7_oagg",   32'(bus.oagg_start),  32'd1);
            skip_to(32); check("stuck_c32_busy",  32'(bus.busy),        32'd1);
                         check("stuck_c32_err",   32'(bus.err),         32'd0);
            skip_to(33); check("stuck_c33_ready", 32'(bus.frame_ready), 32'd1);
                         check("stuck_c33_err",   32'(bus.err),         32'd1);
                         check("stuck_c33_done",  32'(bus.frame_done),  32'd0);
         end
      join

      step(0, 0, 2'd0, 8'h00);
      step(0, 0, 2'd0, 8'h00);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
